// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader (state encoding, header size, checksum seed).
// The CSUM state exists in the encoding always; it is only reachable when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int         HDR_BYTES = 2;
  localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// byte_packer: big-endian S-bit shift register plus a 0..B-1 byte counter.
// last flags that the byte being taken this cycle completes a word; word_next is that word.
module byte_packer #(
  parameter int S = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         take,
  input  logic [7:0]   din,
  output logic [S-1:0] word_next,
  output logic         last
);

  localparam int B  = S / 8;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  logic [S-1:0]  word;
  logic [CW-1:0] cnt;

  assign word_next = (word << 8) | S'(din);
  assign last      = (cnt == CW'(B - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (take) begin
      word <= word_next;
      cnt  <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Byte-stream program loader: 16-bit word-count header, then big-endian words written to instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
// Stream handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready depends only on state.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int S = 32,
  parameter int L = 256,
  localparam int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [S-1:0]  wd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_t        state_dbg
);

  state_t      state;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [15:0] wcnt;
  logic        hcnt;
  logic [15:0] hdr_n;
  logic        take;
  logic        pk_clr;
  logic        pk_take;
  logic        pk_last;
  logic [S-1:0] pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign busy      = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
  assign in_ready  = busy;
  assign state_dbg = state;
  assign take      = in_valid && in_ready;
  assign hdr_n     = {n_hi, in_data};
  assign pk_clr    = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign pk_take   = take && (state == ST_DATA);

  byte_packer #(.S(S)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .take      (pk_take),
    .din       (in_data),
    .word_next (pk_word),
    .last      (pk_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      we      <= 1'b0;
      wa      <= '0;
      wd      <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      n_hi    <= 8'h00;
      n_words <= 16'h0000;
      wcnt    <= 16'h0000;
      hcnt    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum    <= CSUM_INIT;
`endif
    end else begin
      we <= 1'b0;
      // wa holds the written address for the whole we cycle and advances right after it
      if (we) wa <= wa + AW'(1);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_HDR;
            done  <= 1'b0;
            err   <= 1'b0;
            hcnt  <= 1'b0;
            wcnt  <= 16'h0000;
            wa    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= CSUM_INIT;
`endif
          end
        end
        ST_HDR: begin
          if (take) begin
            if (hcnt != 1'(HDR_BYTES - 1)) begin
              n_hi <= in_data;
              hcnt <= 1'b1;
            end else begin
              n_words <= hdr_n;
              hcnt    <= 1'b0;
              if (32'(hdr_n) > 32'(L)) begin
                err   <= 1'b1;
                done  <= 1'b1;
                state <= ST_DONE;
              end else if (hdr_n == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                state <= ST_CSUM;
`else
                state <= ST_DONE;
                done  <= 1'b1;
`endif
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (take) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (pk_last) begin
              we   <= 1'b1;
              wd   <= pk_word;
              wcnt <= wcnt + 16'd1;
              if (wcnt == n_words - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state <= ST_CSUM;
`else
                state <= ST_DONE;
                done  <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (take) begin
            err   <= (in_data != csum);
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized loads of instruction_loader with a write scoreboard.
// Works in both builds; checksum-specific steps appear only when LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;
  import loader_pkg::*;

  localparam int S  = 32;
  localparam int L  = 256;
  localparam int AW = 8;
  localparam int W  = AW + S;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [S-1:0]  wd;
  logic          busy;
  logic          done;
  logic          err;
  state_t        state_dbg;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [7:0]   stim_q[$];

  instruction_loader #(.S(S), .L(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (we) got_q.push_back({wa, wd});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  // gap_mode: 0 none, 1 every other cycle, 2 random
  task automatic run_stream(input int gap_mode);
    bit g;
    while (stim_q.size() > 0) begin
      g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      send_byte(stim_q.pop_front(), g);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !done; i++) tick();
    chk({tag, "_done"}, 64'(done), 64'(1));
    tick();
  endtask

  task automatic push_word(input int addr, input logic [S-1:0] word);
    exp_q.push_back({AW'(addr), word});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_write"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x;
    x = CSUM_INIT;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  initial begin
    logic [7:0] data_b[$];
    logic [S-1:0] w;
    int n;

    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_wa", 64'(wa), 64'(0));
    chk("rst_wd", 64'(wd), 64'(0));
    chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b0;
    tick();

    // two-word load at full rate
    do_start();
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(8'hA8);
`endif
    push_word(0, 32'h20080005);
    push_word(1, 32'h8C090000);
    run_stream(0);
    wait_done("t2");
    chk("t2_err", 64'(err), 64'(0));
    chk("t2_wa", 64'(wa), 64'(2));
    chk("t2_in_ready", 64'(in_ready), 64'(0));
    check_writes("t2");

    // same load with gaps, plus a start pulse mid-load that must be ignored
    do_start();
    stim_q = '{8'h00, 8'h02};
    run_stream(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_busy_start_ignored", 64'(state_dbg), 64'(ST_DATA));
    stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(8'hA8);
`endif
    push_word(0, 32'h20080005);
    push_word(1, 32'h8C090000);
    run_stream(1);
    wait_done("t3");
    chk("t3_err", 64'(err), 64'(0));
    check_writes("t3");

    // oversized header
    do_start();
    stim_q = '{8'h01, 8'h01};
    run_stream(0);
    wait_done("t4");
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_in_ready", 64'(in_ready), 64'(0));
    chk("t4_wa", 64'(wa), 64'(0));
    check_writes("t4");

    // empty load
    do_start();
    stim_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(8'h00);
`endif
    run_stream(0);
    wait_done("t5");
    chk("t5_err", 64'(err), 64'(0));
    check_writes("t5");

    // reset after 5 data bytes
    do_start();
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C};
    push_word(0, 32'h20080005);
    run_stream(0);
    reset = 1'b1;
    tick();
    chk("t6_state", 64'(state_dbg), 64'(ST_IDLE));
    chk("t6_in_ready", 64'(in_ready), 64'(0));
    chk("t6_we", 64'(we), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_done", 64'(done), 64'(0));
    chk("t6_err", 64'(err), 64'(0));
    chk("t6_wa", 64'(wa), 64'(0));
    chk("t6_wd", 64'(wd), 64'(0));
    reset = 1'b0;
    tick();
    check_writes("t6");

`ifdef LOADER_CHECKSUM_EN
    // checksum good and bad
    do_start();
    stim_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    push_word(0, 32'h11223344);
    run_stream(0);
    wait_done("t7a");
    chk("t7a_err", 64'(err), 64'(0));
    check_writes("t7a");
    do_start();
    stim_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    push_word(0, 32'h11223344);
    run_stream(0);
    wait_done("t7b");
    chk("t7b_err", 64'(err), 64'(1));
    check_writes("t7b");
`endif

    // random loads with random gaps
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 5);
      data_b.delete();
      do_start();
      stim_q = '{8'h00, 8'(n)};
      for (int k = 0; k < n; k++) begin
        w = 32'($urandom);
        push_word(k, w);
        for (int j = 3; j >= 0; j--) begin
          stim_q.push_back(w[j*8 +: 8]);
          data_b.push_back(w[j*8 +: 8]);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      stim_q.push_back(xor_of(data_b));
`endif
      run_stream(2);
      wait_done("t8");
      chk("t8_err", 64'(err), 64'(0));
      chk("t8_wa", 64'(wa), 64'(n));
      check_writes("t8");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
